umich_seq_div_op: RTL and testbench
===================================

// Module: umich_seq_div_op
// PURPOSE
//  Multi-cycle restoring divider, the inverse of the UMICH_MULT_*_OP cells.
//  Netlist division operators are mapped onto it where a combinational divide is unacceptable.
//  Accepts dividend/divisor over a valid/ready handshake; returns quotient and remainder
//  over a second valid/ready handshake. One quotient bit is resolved per clock.
// PARAMETERS
//  WIDTH  64  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clocked_on    in   1      clock; all state updates on its rising edge
//  preset        in   1      reset: asynchronous, active-high
//  in_valid      in   1      A/B valid
//  in_ready      out  1      block idle; operands accepted when in_valid & in_ready
//  A             in   WIDTH  dividend
//  B             in   WIDTH  divisor
//  tc            in   1      two's-complement mode (present only with UMICH_SEQ_DIV_TC_EN)
//  out_valid     out  1      Z/R/div_by_zero valid
//  out_ready     in   1      consumer accepts result when out_valid & out_ready
//  Z             out  WIDTH  quotient
//  R             out  WIDTH  remainder
//  div_by_zero   out  1      result was produced with B == 0
// BEHAVIOUR
//  - Reset (preset=1, async): state IDLE, iteration counter 0, out_valid=0, Z=0, R=0,
//    div_by_zero=0. in_ready=1 in IDLE. preset mid-operation aborts it; the operation
//    is lost, with no partial result. Release is sampled on the next clocked_on edge.
//  - FSM: IDLE -> BUSY -> DONE -> IDLE.
//    - in_ready = (state==IDLE): combinational from state only; never from out_ready.
//  - IDLE, handshake in cycle c: latch |A|, |B| (magnitudes, TC mode) and signs; clear
//    the partial remainder.
//    - B==0: go to DONE; out_valid=1 in cycle c+1.
//    - Otherwise go to BUSY with counter=WIDTH-1.
//  - BUSY, one step per edge, MSB first:
//    - Shift the remainder left, bringing in the next dividend bit.
//    - If remainder >= divisor, subtract and set the quotient bit to 1; otherwise set it to 0.
//    - Remainder datapath is WIDTH+1 bits; no overflow is possible.
//    - After WIDTH steps go to DONE; out_valid=1 in cycle c+WIDTH+1.
//  - DONE: out_valid=1. Z, R and div_by_zero are registered and stable while out_valid=1.
//    - out_valid & out_ready -> IDLE; out_valid=0 and in_ready=1 in the next cycle.
//    - Z/R keep their last value until the next result.
//    - Back-to-back issue interval is WIDTH+2 cycles (B!=0, out_ready tied high).
//  - in_valid while not IDLE: ignored; the producer must hold A/B until in_ready.
//    A/B are sampled only at the handshake edge; later changes have no effect.
//  - Unsigned results: Z=floor(A/B), R=A-Z*B.
//  - B==0 results: Z=all ones, R=A, div_by_zero=1.
//    div_by_zero=0 for every other result.
// CONFIGURATION
//  UMICH_SEQ_DIV_TC_EN defined:
//    - Port tc exists, sampled at the input handshake.
//    - tc=1: operands are two's complement. Quotient is truncated toward zero; R takes
//      the sign of A.
//    - Sign fix-up is applied when entering DONE; latency is unchanged.
//    - Overflow: A = most-negative, B = -1 -> Z = A, R = 0, div_by_zero = 0.
//    - tc=0: identical to the unsigned behaviour.
//  UMICH_SEQ_DIV_TC_EN undefined: no tc port; unsigned only; no sign logic synthesised.
// TESTING
//  1. WIDTH=8: A=100, B=7, handshake cycle c -> out_valid cycle c+9, Z=14, R=2, dbz=0.
//  2. WIDTH=8: A=255, B=0 -> out_valid cycle c+1, Z=8'hFF, R=8'hFF, div_by_zero=1.
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid.
//     -> Z/R/out_valid held, in_ready=0 throughout.
//     -> out_ready=1: in_ready=1 the next cycle. A second in_valid pulse during BUSY
//        is not accepted.
//  4. Reset mid-op: preset=1 at BUSY step 3 of A=200, B=3.
//     -> Immediately out_valid=0, Z=0, R=0, in_ready=1.
//     -> Next op A=9, B=4 gives Z=2, R=1.
//  5. TC_EN, WIDTH=8, tc=1:
//     - A=-7, B=2 -> Z=8'hFD (-3), R=8'hFF (-1).
//     - A=-128, B=-1 -> Z=8'h80, R=0.
//     - A=7, B=-2 -> Z=-3, R=1.
//  6. Random regression, WIDTH=64: 10k operand pairs, including 0, 1, all-ones and
//     B>A cases, random in_valid/out_ready gaps.
//     -> Z/R match A/B and A%B; latency exactly WIDTH+1 for B!=0.

Source files
------------

// File: rtl/umich_seq_div_op_if.sv
// rtl/umich_seq_div_op_if.sv - operand/result handshake bundle for umich_seq_div_op
// The tc signal exists only when UMICH_SEQ_DIV_TC_EN is defined.
interface umich_seq_div_op_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
`ifdef UMICH_SEQ_DIV_TC_EN
   logic             tc;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Z;
   logic [WIDTH-1:0] R;
   logic             div_by_zero;

   modport master (
`ifdef UMICH_SEQ_DIV_TC_EN
      output tc,
`endif
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Z, R, div_by_zero
   );

   modport slave (
`ifdef UMICH_SEQ_DIV_TC_EN
      input  tc,
`endif
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Z, R, div_by_zero
   );
endinterface

// File: rtl/umich_seq_div_op.sv
// rtl/umich_seq_div_op.sv - multi-cycle restoring divider, one quotient bit per clock
// Signed (two's-complement) mode is built only when UMICH_SEQ_DIV_TC_EN is defined.
module umich_seq_div_op #(
   parameter int WIDTH = 64
) (
   input logic               clocked_on,
   input logic               preset,
   umich_seq_div_op_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // dividend bits leave at the top while quotient bits enter at the bottom
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;
`ifdef UMICH_SEQ_DIV_TC_EN
   logic             neg_z_q, neg_z_d;
   logic             neg_r_q, neg_r_d;
`endif

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] quo_next, rem_next;

   always_comb begin
`ifdef UMICH_SEQ_DIV_TC_EN
      a_mag = (bus.tc && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      b_mag = (bus.tc && bus.B[WIDTH-1]) ? -bus.B : bus.B;
`else
      a_mag = bus.A;
      b_mag = bus.B;
`endif
   end

   always_comb begin
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      ge       = (rem_sh >= {1'b0, dvsr_q});
      quo_next = {quo_q[WIDTH-2:0], ge};
      rem_next = ge ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvsr_d  = dvsr_q;
      z_d     = z_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
`ifdef UMICH_SEQ_DIV_TC_EN
      neg_z_d = neg_z_q;
      neg_r_d = neg_r_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               quo_d  = a_mag;
               dvsr_d = b_mag;
               rem_d  = '0;
`ifdef UMICH_SEQ_DIV_TC_EN
               neg_z_d = bus.tc && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               neg_r_d = bus.tc && bus.A[WIDTH-1];
`endif
               if (bus.B == '0) begin
                  // R = A holds in both modes, so the raw operand is used
                  z_d     = '1;
                  r_d     = bus.A;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            quo_d = quo_next;
            rem_d = rem_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               z_d   = quo_next;
               r_d   = rem_next;
               dbz_d = 1'b0;
`ifdef UMICH_SEQ_DIV_TC_EN
               if (neg_z_q) z_d = -quo_next;
               if (neg_r_q) r_d = -rem_next;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clocked_on or posedge preset) begin
      if (preset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvsr_q  <= '0;
         z_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
`ifdef UMICH_SEQ_DIV_TC_EN
         neg_z_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvsr_q  <= dvsr_d;
         z_q     <= z_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
`ifdef UMICH_SEQ_DIV_TC_EN
         neg_z_q <= neg_z_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.Z           = z_q;
   assign bus.R           = r_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_umich_seq_div_op.sv
// tb/tb_umich_seq_div_op.sv - scoreboard bench for umich_seq_div_op at WIDTH=8
module tb_umich_seq_div_op;
   localparam int W = 8;

   logic clocked_on = 1'b0;
   logic preset     = 1'b1;
   int   cyc        = 0;
   int   n_checks   = 0;
   int   n_fail     = 0;
   int   hs_last    = 0;
   int   hs_prev    = 0;

   typedef struct {
      logic [W-1:0] z;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
      int           c;
   } exp_t;

   exp_t sb[$];

   always #5 clocked_on = ~clocked_on;
   always @(posedge clocked_on) cyc <= cyc + 1;

   umich_seq_div_op_if #(.WIDTH(W)) bus ();

   umich_seq_div_op #(.WIDTH(W)) dut (
      .clocked_on (clocked_on),
      .preset     (preset),
      .bus        (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic t,
                        input logic [W-1:0] ez, input logic [W-1:0] er, input logic edbz);
      exp_t e;
      int   n;
      n = 0;
      bus.A        = a;
      bus.B        = b;
`ifdef UMICH_SEQ_DIV_TC_EN
      bus.tc       = t;
`endif
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clocked_on);
         if (bus.in_ready) break;
         n++;
         if (n > 100) begin
            check("issue_timeout", 64'd0, 64'd1);
            break;
         end
      end
      e.z   = ez;
      e.r   = er;
      e.dbz = edbz;
      e.lat = (b == '0) ? 1 : W + 1;
      e.c   = cyc;
      sb.push_back(e);
      hs_prev = hs_last;
      hs_last = cyc;
      @(posedge clocked_on);
      #1;
      bus.in_valid = 1'b0;
      if (t) bus.A = ~a;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clocked_on);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
      #1;
   endtask

   // monitor: latency at the rising out_valid, payload at the output handshake
   initial begin
      exp_t e;
      logic prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clocked_on);
         if (preset) begin
            prev_ov = 1'b0;
         end else begin
            if (bus.out_valid && !prev_ov) begin
               if (sb.size() == 0) check("unexpected_result", 64'd1, 64'd0);
               else check("latency", 64'(cyc - sb[0].c), 64'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("Z", 64'(bus.Z), 64'(e.z));
               check("R", 64'(bus.R), 64'(e.r));
               check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            end
            prev_ov = bus.out_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.A         = '0;
      bus.B         = '0;
`ifdef UMICH_SEQ_DIV_TC_EN
      bus.tc        = 1'b0;
`endif
      repeat (2) @(posedge clocked_on);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_Z", 64'(bus.Z), 64'd0);
      check("rst_R", 64'(bus.R), 64'd0);
      check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      preset = 1'b0;
      @(posedge clocked_on);
      #1;

      issue(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0);
      drain();
      issue(8'd255, 8'd0, 1'b0, 8'hFF, 8'hFF, 1'b1);
      drain();

      // back-to-back issue interval with out_ready high
      issue(8'd200, 8'd16, 1'b0, 8'd12, 8'd8, 1'b0);
      issue(8'd13, 8'd2, 1'b0, 8'd6, 8'd1, 1'b0);
      check("issue_interval", 64'(hs_last - hs_prev), 64'(W + 2));
      issue(8'd0, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
      issue(8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0);
      issue(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
      issue(8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0);
      issue(8'd254, 8'd127, 1'b0, 8'd2, 8'd0, 1'b0);
      issue(8'd1, 8'd0, 1'b0, 8'hFF, 8'd1, 1'b1);
      drain();

      // backpressure, plus an in_valid pulse while busy that must be ignored
      bus.out_ready = 1'b0;
      issue(8'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0);
      bus.A = 8'd1;
      bus.B = 8'd1;
      bus.in_valid = 1'b1;
      @(negedge clocked_on);
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clocked_on);
      #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clocked_on);
         #1;
         n++;
      end
      check("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clocked_on);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_Z", 64'(bus.Z), 64'd10);
         check("bp_R", 64'(bus.R), 64'd0);
      end
      @(posedge clocked_on);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clocked_on);
      @(negedge clocked_on);
      check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
      repeat (3) @(negedge clocked_on);
      check("bp_pulse_ignored", 64'(bus.out_valid), 64'd0);
      @(posedge clocked_on);
      #1;

      // reset during BUSY wipes the operation and the result registers
      issue(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0);
      drain();
      issue(8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 1'b0);
      repeat (2) @(posedge clocked_on);
      #1;
      preset = 1'b1;
      sb.delete();
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_Z", 64'(bus.Z), 64'd0);
      check("abort_R", 64'(bus.R), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clocked_on);
      #1;
      preset = 1'b0;
      issue(8'd9, 8'd4, 1'b0, 8'd2, 8'd1, 1'b0);
      drain();

`ifdef UMICH_SEQ_DIV_TC_EN
      issue(8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0);
      issue(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
      issue(8'd7, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
      issue(8'hF9, 8'd2, 1'b0, 8'h7C, 8'h01, 1'b0);
      issue(8'hF9, 8'd0, 1'b1, 8'hFF, 8'hF9, 1'b1);
      drain();
`endif

      repeat (2) @(posedge clocked_on);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
